// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch unit: FSM encoding and PC constants.
// The optional fetch watchdog is enabled by defining IFETCH_TIMEOUT_EN.
package ifetch_pkg;

   typedef enum logic {
      FETCH = 1'b0,
      IDLE  = 1'b1
   } fetch_state_e;

   localparam logic [31:0] RESET_PC       = 32'h0000_0000;
   localparam int          TIMEOUT_CYCLES = 16;
   localparam int          TIMEOUT_W      = 4;
   localparam logic [31:0] PC_INCR        = 32'd4;

endpackage

// File: rtl/ifetch_pc_next.sv
// Combinational next-PC: sequential PC+4 or branch target PC+4+(Imm<<2), modulo 2^32.
module ifetch_pc_next
   import ifetch_pkg::*;
(
   input  logic [31:0] PC,
   input  logic        PC_Sel,
   input  logic [31:0] Imm,
   output logic [31:0] next_pc
);

   logic [31:0] offset;

   always_comb begin
      offset  = PC_Sel ? (Imm << 2) : 32'd0;
      next_pc = PC + PC_INCR + offset;
   end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch unit: PC register, FETCH/IDLE request FSM, one-deep deferred PC
// update, frozen-IR shadow word. Define IFETCH_TIMEOUT_EN to add the fetch watchdog.
module ifetch_unit
   import ifetch_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic        PC_LdEn,
   input  logic        PC_Sel,
   input  logic [31:0] Imm,
   input  logic        Sel_Instr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Instr,
   output logic [31:0] PC,
   output logic        fetch_busy,
   output logic        fetch_timeout
);

   // Memory handshake: imem_req and imem_addr stay stable from issue until the
   // cycle imem_ack is seen high with imem_req high; that edge completes the read.

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q;
   logic [31:0]  ir_q;
   logic [31:0]  shadow_q;
   logic         shadow_valid_q;
   logic         pend_valid_q;
   logic         pend_sel_q;
   logic [31:0]  pend_imm_q;

   logic         timeout_gap;
   logic         ack_fire;
   logic         pc_load;
   logic         pend_set;
   logic         pend_clr;
   logic         ld_sel;
   logic [31:0]  ld_imm;
   logic [31:0]  pc_target;

   assign ack_fire = (state_q == FETCH) && imem_ack && !timeout_gap;

   // A recorded update takes precedence over the live inputs when the ack lands.
   assign ld_sel = pend_valid_q ? pend_sel_q : PC_Sel;
   assign ld_imm = pend_valid_q ? pend_imm_q : Imm;

   ifetch_pc_next u_pc_next (
      .PC      (pc_q),
      .PC_Sel  (ld_sel),
      .Imm     (ld_imm),
      .next_pc (pc_target)
   );

   always_comb begin
      state_d  = state_q;
      pc_load  = 1'b0;
      pend_set = 1'b0;
      pend_clr = 1'b0;
      case (state_q)
         FETCH: begin
            if (ack_fire) begin
               if (pend_valid_q || PC_LdEn) begin
                  pc_load  = 1'b1;
                  pend_clr = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else if (PC_LdEn && !pend_valid_q) begin
               pend_set = 1'b1;
            end
         end
         IDLE: begin
            if (PC_LdEn) begin
               pc_load = 1'b1;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         pend_valid_q <= 1'b0;
         pend_sel_q   <= 1'b0;
         pend_imm_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         if (pc_load) begin
            pc_q <= pc_target;
         end
         if (pend_set) begin
            pend_valid_q <= 1'b1;
            pend_sel_q   <= PC_Sel;
            pend_imm_q   <= Imm;
         end else if (pend_clr) begin
            pend_valid_q <= 1'b0;
         end
      end
   end

   // While frozen the acked word parks in the shadow; on unfreeze a fresh ack wins.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ir_q           <= 32'd0;
         shadow_q       <= 32'd0;
         shadow_valid_q <= 1'b0;
      end else if (Sel_Instr) begin
         if (ack_fire) begin
            shadow_q       <= imem_rdata;
            shadow_valid_q <= 1'b1;
         end
      end else begin
         if (ack_fire) begin
            ir_q <= imem_rdata;
         end else if (shadow_valid_q) begin
            ir_q <= shadow_q;
         end
         shadow_valid_q <= 1'b0;
      end
   end

`ifdef IFETCH_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] wait_cnt_q;
   logic                 gap_q;
   logic                 timeout_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt_q <= '0;
         gap_q      <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         gap_q <= 1'b0;
         if ((state_q == FETCH) && !gap_q && !imem_ack) begin
            if (wait_cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
               wait_cnt_q <= '0;
               gap_q      <= 1'b1;
               timeout_q  <= 1'b1;
            end else begin
               wait_cnt_q <= wait_cnt_q + 1'b1;
            end
         end else begin
            wait_cnt_q <= '0;
         end
      end
   end

   assign timeout_gap   = gap_q;
   assign fetch_timeout = timeout_q;
`else
   assign timeout_gap   = 1'b0;
   assign fetch_timeout = 1'b0;
`endif

   // Request is forced low for the whole time reset is held.
   assign imem_req   = reset_n && (state_q == FETCH) && !timeout_gap;
   assign imem_addr  = pc_q;
   assign PC         = pc_q;
   assign Instr      = ir_q;
   assign fetch_busy = (state_q == FETCH) || shadow_valid_q || pend_valid_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios then randomized traffic, with fetch
// addresses and instruction words scoreboarded against a cycle-level reference model.
module tb_ifetch_unit;

   logic        clock      = 1'b0;
   logic        reset_n    = 1'b0;
   logic        PC_LdEn    = 1'b0;
   logic        PC_Sel     = 1'b0;
   logic [31:0] Imm        = 32'd0;
   logic        Sel_Instr  = 1'b0;
   logic        imem_ack   = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] Instr;
   logic [31:0] PC;
   logic        fetch_busy;
   logic        fetch_timeout;

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_q[$];
   logic [31:0] ir_q[$];

   // reference model state
   logic        m_fetch  = 1'b0;
   logic        m_pend   = 1'b0;
   logic        m_shadow = 1'b0;
   logic        m_gap    = 1'b0;
   logic        m_to     = 1'b0;
   logic [31:0] m_pc     = 32'd0;
   logic [31:0] m_pend_pc = 32'd0;
   int          m_cnt    = 0;

   ifetch_unit dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .PC_LdEn       (PC_LdEn),
      .PC_Sel        (PC_Sel),
      .Imm           (Imm),
      .Sel_Instr     (Sel_Instr),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .Instr         (Instr),
      .PC            (PC),
      .fetch_busy    (fetch_busy),
      .fetch_timeout (fetch_timeout)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_next(input logic [31:0] pc, input logic sel,
                                              input logic [31:0] imm);
      return sel ? pc + 32'd4 + imm * 32'd4 : pc + 32'd4;
   endfunction

   // One clock of stimulus; the model advances as of the edge these inputs are sampled on.
   task automatic step(input logic ld, input logic sel, input logic [31:0] imm,
                       input logic ack, input logic [31:0] rd, input logic frz);
      logic acc;
      logic was_fetch;
      PC_LdEn    = ld;
      PC_Sel     = sel;
      Imm        = imm;
      imem_ack   = ack;
      imem_rdata = rd;
      Sel_Instr  = frz;
      was_fetch  = m_fetch;
      acc        = m_fetch && ack && !m_gap;
      if (acc) ir_q.push_back(rd);
      if (acc || !frz) m_shadow = acc && frz;
      if (!m_fetch) begin
         if (ld) begin
            m_pc    = model_next(m_pc, sel, imm);
            m_fetch = 1'b1;
            exp_q.push_back(m_pc);
         end
      end else if (acc) begin
         if (m_pend) begin
            m_pc   = m_pend_pc;
            m_pend = 1'b0;
            exp_q.push_back(m_pc);
         end else if (ld) begin
            m_pc = model_next(m_pc, sel, imm);
            exp_q.push_back(m_pc);
         end else begin
            m_fetch = 1'b0;
         end
      end else if (ld && !m_pend) begin
         m_pend    = 1'b1;
         m_pend_pc = model_next(m_pc, sel, imm);
      end
`ifdef IFETCH_TIMEOUT_EN
      if (was_fetch && !m_gap && !acc) begin
         m_cnt++;
         if (m_cnt == 16) begin
            m_cnt = 0;
            m_to  = 1'b1;
            m_gap = 1'b1;
            exp_q.push_back(m_pc);
         end
      end else begin
         m_cnt = 0;
         m_gap = 1'b0;
      end
`else
      if (was_fetch) m_cnt = 0;
`endif
      @(posedge clock);
      #1;
      chk("pc", PC, m_pc);
      chk("imem_req", 32'(imem_req), 32'(m_fetch && !m_gap));
      chk("fetch_busy", 32'(fetch_busy), 32'(m_fetch || m_pend || m_shadow));
      chk("fetch_timeout", 32'(fetch_timeout), 32'(m_to));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      PC_LdEn   = 1'b0;
      imem_ack  = 1'b0;
      Sel_Instr = 1'b0;
      #1;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_pc", PC, 32'h0000_0000);
      chk("rst_instr", Instr, 32'd0);
      chk("rst_timeout", 32'(fetch_timeout), 32'd0);
      chk("rst_busy", 32'(fetch_busy), 32'd1);
      m_fetch  = 1'b1;
      m_pend   = 1'b0;
      m_shadow = 1'b0;
      m_gap    = 1'b0;
      m_to     = 1'b0;
      m_pc     = 32'd0;
      m_cnt    = 0;
      exp_q.delete();
      ir_q.delete();
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      exp_q.push_back(32'd0);
   endtask

   // Monitor: pops an expected address on each new request and a word on each accepted ack.
   initial begin
      logic        p_req = 1'b0;
      logic        p_acc = 1'b0;
      logic        p_sel = 1'b0;
      logic        mon_sv = 1'b0;
      logic [31:0] mon_ir = 32'd0;
      logic [31:0] mon_sw = 32'd0;
      logic [31:0] last_exp = 32'd0;
      logic [31:0] w;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            p_req  = 1'b0;
            p_acc  = 1'b0;
            p_sel  = 1'b0;
            mon_sv = 1'b0;
            mon_ir = 32'd0;
         end else begin
            if (imem_req && (!p_req || p_acc)) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL addr_unexpected actual=%h required=no request", imem_addr);
               end else begin
                  last_exp = exp_q.pop_front();
                  chk("imem_addr", imem_addr, last_exp);
               end
            end else if (imem_req) begin
               chk("addr_hold", imem_addr, last_exp);
            end
            if (p_acc) begin
               if (ir_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL ack_unexpected actual=accepted required=ignored");
               end else begin
                  w = ir_q.pop_front();
                  if (p_sel) begin
                     mon_sw = w;
                     mon_sv = 1'b1;
                  end else begin
                     mon_ir = w;
                     mon_sv = 1'b0;
                  end
               end
            end else if (!p_sel && mon_sv) begin
               mon_ir = mon_sw;
               mon_sv = 1'b0;
            end
            chk("instr", Instr, mon_ir);
            p_req = imem_req;
            p_acc = imem_req && imem_ack;
            p_sel = Sel_Instr;
         end
      end
   end

   initial begin
      logic frz;
      do_reset();

      // first fetch at 0, acked two cycles after release
      idle(2);
      step(1'b0, 1'b0, 32'd0, 1'b1, 32'h2001_0005, 1'b0);
      chk("first_instr", Instr, 32'h2001_0005);
      idle(1);

      // branch to 0x100, then backwards by two words to 0xFC
      step(1'b1, 1'b1, 32'h0000_003F, 1'b0, 32'd0, 1'b0);
      chk("br_pc_100", PC, 32'h0000_0100);
      step(1'b0, 1'b0, 32'd0, 1'b1, $urandom, 1'b0);
      step(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'd0, 1'b0);
      chk("neg_imm_pc", PC, 32'h0000_00FC);
      chk("neg_imm_addr", imem_addr, 32'h0000_00FC);
      step(1'b0, 1'b0, 32'd0, 1'b1, $urandom, 1'b0);

      // top of address space, sequential step wraps to 0
      step(1'b1, 1'b1, 32'hFFFF_FFBF, 1'b0, 32'd0, 1'b0);
      chk("top_pc", PC, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 32'd0, 1'b1, $urandom, 1'b0);
      step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      chk("wrap_pc", PC, 32'h0000_0000);
      chk("wrap_addr", imem_addr, 32'h0000_0000);
      step(1'b0, 1'b0, 32'd0, 1'b1, 32'h1111_1111, 1'b0);

      // frozen IR while an ack arrives
      step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b1);
      chk("frozen_instr_a", Instr, 32'h1111_1111);
      step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
      chk("frozen_instr_b", Instr, 32'h1111_1111);
      step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      chk("unfrozen_instr", Instr, 32'hDEAD_BEEF);

      // two loads during a five-cycle fetch: first deferred, second dropped
      step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      step(1'b1, 1'b1, 32'd5, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b1, $urandom, 1'b0);
      chk("pending_pc", PC, 32'h0000_0020);
      step(1'b0, 1'b0, 32'd0, 1'b1, $urandom, 1'b0);
      idle(1);

      // stalled fetch: watchdog fires only when built in
      step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      idle(20);
`ifdef IFETCH_TIMEOUT_EN
      chk("timeout_flag", 32'(fetch_timeout), 32'd1);
`else
      chk("timeout_flag", 32'(fetch_timeout), 32'd0);
`endif
      chk("stalled_pc", PC, 32'h0000_0024);
      step(1'b0, 1'b0, 32'd0, 1'b1, $urandom, 1'b0);

      // reset in the middle of a fetch, then a late ack taken by the new fetch
      step(1'b1, 1'b1, 32'd100, 1'b0, 32'd0, 1'b0);
      idle(1);
      do_reset();
      step(1'b0, 1'b0, 32'd0, 1'b1, 32'hCAFE_0001, 1'b0);
      chk("post_reset_instr", Instr, 32'hCAFE_0001);

      // randomized traffic
      frz = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 5) == 0) frz = ~frz;
         step(($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom,
              ($urandom_range(0, 2) == 0), $urandom, frz);
      end

      // drain
      for (int i = 0; i < 40 && (m_fetch || m_pend); i++)
         step(1'b0, 1'b0, 32'd0, 1'b1, $urandom, 1'b0);
      idle(2);
      chk("addr_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("word_queue_empty", 32'(ir_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL provide the following ports, clock and reset first:
  clock  input  1  sole clock, all state updates on its rising edge
  reset_n  input  1  asynchronous, active-low reset
  PC_LdEn  input  1  from control FSM: advance PC and start a fetch
  PC_Sel  input  1  sampled with PC_LdEn: 0 = sequential, 1 = branch target
  Imm  input  32  sign-extended word offset, sampled with PC_LdEn
  Sel_Instr  input  1  1 = freeze the Instr output
  imem_req  output  1  instruction-memory read request
  imem_addr  output  32  instruction-memory byte address
  imem_ack  input  1  read data valid this cycle
  imem_rdata  input  32  instruction word
  Instr  output  32  current instruction register (IR) to control and datapath
  PC  output  32  current program counter
  fetch_busy  output  1  fetch in progress or deferred word pending; control SHALL stall
  fetch_timeout  output  1  sticky watchdog flag
REQ-002 SHALL use one clock (clock); reset_n SHALL be asynchronous and active-low.

Function
REQ-003 SHALL implement FSM states FETCH and IDLE.
REQ-004 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal PC, both held stable until imem_ack.
REQ-005 On imem_ack in FETCH, the word SHALL be captured the same edge and the FSM SHALL move to IDLE; imem_req SHALL be 0 next cycle.
REQ-006 imem_ack outside FETCH SHALL be ignored.
REQ-007 In IDLE, PC_LdEn=1 SHALL load PC with PC+4 (PC_Sel=0) or PC+4+(Imm<<2) (PC_Sel=1), and the FSM SHALL move to FETCH, issuing the new address next cycle.
REQ-008 PC arithmetic SHALL be 32-bit modulo 2^32: 0xFFFFFFFC+4 = 0x00000000; negative Imm SHALL wrap likewise.
REQ-009 PC_LdEn in FETCH SHALL be recorded in a one-deep pending slot (PC_Sel, Imm captured); on ack the pending update SHALL apply and the FSM SHALL re-enter FETCH directly.
REQ-010 A further PC_LdEn while the pending slot is full SHALL be dropped.
REQ-011 PC_LdEn coincident with imem_ack SHALL be treated as pending (REQ-009).
REQ-012 While Sel_Instr=1, IR SHALL not change; an acked word SHALL go to a shadow register with a valid bit.
REQ-013 On the first cycle Sel_Instr=0 with shadow valid, IR SHALL load the shadow word and clear valid; a new ack that cycle SHALL overwrite IR after the shadow word.
REQ-014 fetch_busy SHALL equal (state==FETCH) OR shadow valid OR pending slot full.
REQ-015 Instr SHALL be IR; PC SHALL be the PC register; both registered.

Reset
REQ-016 On reset_n=0, immediately: PC=0x00000000, IR=0, shadow/pending cleared, fetch_timeout=0, state=FETCH, imem_req=0 while reset is asserted.
REQ-017 After release, the first cycle SHALL issue imem_req with address 0; a fetch in flight at reset SHALL be abandoned and a late ack ignored unless in the new FETCH.

Configuration
REQ-018 Macro IFETCH_TIMEOUT_EN defined: a 4-bit counter SHALL count FETCH cycles without ack; at 16 cycles fetch_timeout SHALL set (sticky until reset), imem_req SHALL drop one cycle, then re-issue the same address with the counter cleared.
REQ-019 Macro undefined: no counter, FETCH SHALL wait indefinitely, fetch_timeout SHALL be tied 0; port list unchanged.

Structure
REQ-020 Package ifetch_pkg SHALL hold the state encoding, RESET_PC (0x00000000), TIMEOUT_CYCLES (16) and PC_INCR (4).
REQ-021 Next-PC computation SHALL be the combinational sub-module ifetch_pc_next (inputs PC, PC_Sel, Imm; output next PC).

Verification
REQ-022 Reset release, ack 2 cycles later with 0x20010005 -> imem_addr=0, Instr=0x20010005, fetch_busy low after ack.
REQ-023 IDLE, PC=0x100, PC_LdEn=1, PC_Sel=1, Imm=0xFFFFFFFE -> PC=0xFC, imem_addr=0xFC next cycle.
REQ-024 PC=0xFFFFFFFC, PC_LdEn=1, PC_Sel=0 -> PC=0x00000000, fetch at 0.
REQ-025 Sel_Instr=1 during ack of 0xDEADBEEF -> Instr unchanged until Sel_Instr falls, then 0xDEADBEEF next edge.
REQ-026 PC_LdEn twice during a 5-cycle FETCH -> first applied after ack, second dropped; with IFETCH_TIMEOUT_EN and no ack for 16 cycles -> fetch_timeout=1, request re-issued at same address.
